// File: rtl/skylark_mem_arbiter.sv
// Shares one single-port memory between fetch (read-only) and data (read/write) with a timeout watchdog.
// Define SKYLARK_ARB_RR_EN for round-robin; otherwise data has priority, with a fetch starvation guard.
module skylark_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy,
    output logic              o_bus_err,
    output logic [1:0]        o_dbg_state
);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_XFER_I = 2'd1,
        ST_XFER_D = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_if_rvalid;
    logic              r_d_rvalid;
    logic              r_bus_err;
    logic              w_fetch_first;
    logic              w_if_gnt;
    logic              w_d_gnt;
    logic              w_xfer;
    logic              w_ack;
    logic              w_abort;

`ifdef SKYLARK_ARB_RR_EN
    logic r_last_d;

    // Fetch wins a tie whenever data owned the memory last.
    assign w_fetch_first = r_last_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      r_last_d <= 1'b1;
        else if (w_if_gnt) r_last_d <= 1'b0;
        else if (w_d_gnt)  r_last_d <= 1'b1;
    end
`else
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    logic [SC_W-1:0] r_starve_cnt;

    assign w_fetch_first = (r_starve_cnt == SC_W'(STARVE_LIMIT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                          r_starve_cnt <= '0;
        else if (!i_if_req || w_if_gnt)        r_starve_cnt <= '0;
        else if (w_d_gnt && !w_fetch_first)    r_starve_cnt <= r_starve_cnt + 1'b1;
    end
`endif

    assign w_if_gnt = (r_state == ST_IDLE) && i_if_req && (!i_d_req || w_fetch_first);
    assign w_d_gnt  = (r_state == ST_IDLE) && i_d_req && (!i_if_req || !w_fetch_first);
    assign w_xfer   = (r_state == ST_XFER_I) || (r_state == ST_XFER_D);
    assign w_ack    = w_xfer && i_mem_ack;
    // An ack on the final allowed cycle takes precedence over the abort.
    assign w_abort  = w_xfer && !i_mem_ack && (r_to_cnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_if_gnt)     w_next = ST_XFER_I;
                else if (w_d_gnt) w_next = ST_XFER_D;
            end
            ST_XFER_I, ST_XFER_D: begin
                if (w_ack || w_abort) w_next = ST_RESP;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_bus_err   <= 1'b0;
            if (w_if_gnt) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= i_if_addr;
                r_to_cnt   <= '0;
            end else if (w_d_gnt) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= i_d_we;
                r_mem_addr  <= i_d_addr;
                r_mem_wdata <= i_d_wdata;
                r_to_cnt    <= '0;
            end else if (w_ack || w_abort) begin
                r_mem_req <= 1'b0;
                r_bus_err <= w_abort;
                if (r_state == ST_XFER_I) begin
                    r_if_rvalid <= 1'b1;
                    r_if_rdata  <= w_ack ? i_mem_rdata : '0;
                end else begin
                    r_d_rvalid <= 1'b1;
                    // Writes complete without disturbing the last read data.
                    if (!r_mem_we) r_d_rdata <= w_ack ? i_mem_rdata : '0;
                end
            end else if (w_xfer) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign o_if_gnt    = w_if_gnt;
    assign o_d_gnt     = w_d_gnt;
    assign o_if_rvalid = r_if_rvalid;
    assign o_d_rvalid  = r_d_rvalid;
    assign o_if_rdata  = r_if_rdata;
    assign o_d_rdata   = r_d_rdata;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_bus_err   = r_bus_err;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_skylark_mem_arbiter.sv
// Directed testbench for skylark_mem_arbiter: single transfers, write, contention, timeout, reset abort, back-to-back.
module tb_skylark_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] if_rdata, d_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy, bus_err;
  logic [1:0]    dbg_state;

  // Memory responder controls
  logic          resp_ack = 1'b0;
  logic          late_ack = 1'b0;
  int            ack_delay = 0;
  int            mem_cyc = 0;
  logic [DW-1:0] mem_val = '0;
  bit            addr_data = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  bit            exp_own_q[$];

  assign mem_ack = resp_ack | late_ack;

  skylark_mem_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_busy(busy), .o_bus_err(bus_err), .o_dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory model: acks in mem_req cycle number ack_delay+1 (never when ack_delay<0)
  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      mem_cyc++;
      resp_ack = (ack_delay >= 0) && (mem_cyc == ack_delay + 1);
      mem_rdata = addr_data ? (mem_addr ^ 32'h5A5A_0000) : mem_val;
    end else begin
      mem_cyc = 0;
      resp_ack = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    int  n;
    int  grants;
    bit  drop;
    bit  own;
    bit  exp_f;
    logic [DW-1:0] e;

    rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    cyc(); cyc();
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_state", dbg_state, 0);
    check_eq("rst_outs", {if_rvalid, d_rvalid, bus_err, mem_we}, 0);
    check_eq("rst_rdata", {if_rdata, d_rdata}, 0);
    cyc(); rst_n = 1'b1;

    // Single fetch, ack in the first mem_req cycle
    ack_delay = 0; mem_val = 32'hDEAD_BEEF;
    cyc(); if_req = 1; if_addr = 32'h100; #1;
    check_eq("f1_gnt", if_gnt, 1);
    check_eq("f1_busy_T", busy, 0);
    cyc(); if_req = 0; #1;
    check_eq("f1_mem_req", mem_req, 1);
    check_eq("f1_mem_addr", mem_addr, 32'h100);
    check_eq("f1_mem_we", mem_we, 0);
    check_eq("f1_no_early_rvalid", if_rvalid, 0);
    cyc(); #1;
    check_eq("f1_rvalid", if_rvalid, 1);
    check_eq("f1_rdata", if_rdata, 32'hDEAD_BEEF);
    check_eq("f1_mem_req_low", mem_req, 0);
    check_eq("f1_d_rvalid", d_rvalid, 0);
    cyc(); #1;
    check_eq("f1_rvalid_pulse", if_rvalid, 0);
    check_eq("f1_idle", busy, 0);
    check_eq("f1_rdata_hold", if_rdata, 32'hDEAD_BEEF);

    // Data read, ack in the second cycle
    ack_delay = 1; mem_val = 32'hCAFE_0001;
    cyc(); d_req = 1; d_we = 0; d_addr = 32'h40; #1;
    check_eq("dr_gnt", {if_gnt, d_gnt}, 2'b01);
    cyc(); d_req = 0; #1;
    check_eq("dr_mem", {mem_req, mem_we}, 2'b10);
    check_eq("dr_mem_addr", mem_addr, 32'h40);
    cyc(); #1;
    check_eq("dr_not_yet", d_rvalid, 0);
    cyc(); #1;
    check_eq("dr_rvalid", d_rvalid, 1);
    check_eq("dr_rdata", d_rdata, 32'hCAFE_0001);
    check_eq("dr_if_rdata_hold", if_rdata, 32'hDEAD_BEEF);

    // Write, ack after 3 cycles; inputs scrambled after grant
    ack_delay = 2; mem_val = 32'hBBBB_BBBB;
    cyc(); d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h1234_5678; #1;
    check_eq("wr_gnt", d_gnt, 1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (k == 0) begin d_req = 0; d_we = 0; d_addr = 32'hFFFF_0000; d_wdata = '0; end
      #1;
      check_eq($sformatf("wr_req_we_%0d", k), {mem_req, mem_we, d_rvalid}, 3'b110);
      check_eq($sformatf("wr_addr_%0d", k), mem_addr, 32'h2000);
      check_eq($sformatf("wr_wdata_%0d", k), mem_wdata, 32'h1234_5678);
    end
    cyc(); #1;
    check_eq("wr_rvalid", d_rvalid, 1);
    check_eq("wr_rdata_unchanged", d_rdata, 32'hCAFE_0001);
    check_eq("wr_no_err", bus_err, 0);
    cyc(); #1;
    check_eq("wr_rvalid_pulse", d_rvalid, 0);
    check_eq("wr_idle", busy, 0);

    // Timeout: memory never acks
    ack_delay = -1;
    cyc(); d_req = 1; d_we = 0; d_addr = 32'h300; #1;
    check_eq("to_gnt", d_gnt, 1);
    cyc(); d_req = 0; #1;
    n = 0;
    while (mem_req && n < 40) begin n++; cyc(); #1; end
    check_eq("to_req_cycles", n, 15);
    check_eq("to_bus_err", bus_err, 1);
    check_eq("to_rvalid", d_rvalid, 1);
    check_eq("to_rdata_zero", d_rdata, 0);
    check_eq("to_if_rvalid", if_rvalid, 0);
    late_ack = 1;
    cyc(); #1;
    check_eq("to_late_ack_idle", {busy, d_rvalid, bus_err, if_rvalid}, 0);
    cyc(); #1;
    check_eq("to_late_ack_ignored", {busy, d_rvalid, bus_err}, 0);
    late_ack = 0;

    // Ack on the final allowed cycle wins over the abort
    ack_delay = 14; mem_val = 32'h5EED_0015;
    cyc(); d_req = 1; d_we = 0; d_addr = 32'h310; #1;
    check_eq("tb_gnt", d_gnt, 1);
    cyc(); d_req = 0; #1;
    n = 0;
    while (mem_req && n < 40) begin n++; cyc(); #1; end
    check_eq("tb_req_cycles", n, 15);
    check_eq("tb_no_err", bus_err, 0);
    check_eq("tb_rvalid", d_rvalid, 1);
    check_eq("tb_rdata", d_rdata, 32'h5EED_0015);

    // Reset mid-transfer
    ack_delay = -1;
    cyc(); if_req = 1; if_addr = 32'h500; #1;
    check_eq("rx_gnt", if_gnt, 1);
    cyc(); if_req = 0; #1;
    check_eq("rx_mem_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rx_async_drop", mem_req, 0);
    check_eq("rx_busy", busy, 0);
    cyc(); #1;
    check_eq("rx_no_rvalid", {if_rvalid, bus_err}, 0);
    cyc(); rst_n = 1'b1; #1;
    check_eq("rx_rdata_cleared", if_rdata, 0);
    ack_delay = 0; mem_val = 32'h0BAD_F00D;
    cyc(); if_req = 1; if_addr = 32'h600; #1;
    check_eq("rx_regnt", if_gnt, 1);
    cyc(); if_req = 0; #1;
    check_eq("rx_mem_addr", mem_addr, 32'h600);
    cyc(); #1;
    check_eq("rx_rvalid", if_rvalid, 1);
    check_eq("rx_rdata", if_rdata, 32'h0BAD_F00D);

    // Contention: both requesters held for 12 grants
    addr_data = 1; ack_delay = 0;
    cyc(); if_req = 1; if_addr = 32'h1000; d_req = 1; d_we = 0; d_addr = 32'h2000;
    grants = 0; drop = 0;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) cyc();
      if (drop) begin if_req = 0; d_req = 0; end
      #1;
      if (if_rvalid || d_rvalid) begin
        check_eq("cont_rvalid_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          own = exp_own_q.pop_front();
          e = exp_q.pop_front();
          check_eq("cont_rvalid_owner", if_rvalid, own);
          check_eq("cont_rdata", own ? if_rdata : d_rdata, e);
        end
      end
      if (if_gnt || d_gnt) begin
        check_eq("cont_excl", if_gnt & d_gnt, 0);
`ifdef SKYLARK_ARB_RR_EN
        exp_f = (grants % 2 == 0);
`else
        exp_f = (grants % 5 == 4);
`endif
        check_eq($sformatf("cont_winner_%0d", grants), if_gnt, exp_f);
        exp_own_q.push_back(if_gnt);
        exp_q.push_back((if_gnt ? 32'h1000 : 32'h2000) ^ 32'h5A5A_0000);
        grants++;
        if (grants == 12) drop = 1;
      end
      if (grants == 12 && exp_q.size() == 0 && !busy) break;
    end
    check_eq("cont_grants", grants, 12);
    check_eq("cont_drained", exp_q.size(), 0);
    addr_data = 0;

    // Back-to-back: d_req held, ack in the first cycle
    ack_delay = 0; mem_val = 32'h1111_0000;
    cyc(); d_req = 1; d_we = 0; d_addr = 32'h700;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) cyc();
      #1;
      check_eq($sformatf("b2b_gnt_%0d", i), d_gnt, (i % 3 == 0));
      check_eq($sformatf("b2b_busy_%0d", i), busy, (i % 3 != 0));
    end
    cyc(); d_req = 0;
    n = 0;
    while (busy && n < 20) begin n++; cyc(); end
    #1;
    check_eq("b2b_final_idle", busy, 0);
    check_eq("b2b_rdata", d_rdata, 32'h1111_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
